// File: rtl/mux4_rr_arbiter_pkg.sv
// mux4_arb_pkg: shared width constant, select type and arbiter state encoding
package mux4_arb_pkg;
  localparam int N_REQ = 4;
  typedef logic [1:0] sel_t;
  typedef enum logic {IDLE, GRANT} arb_state_e;
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: combinational round-robin finder over four requests
// ports: req (requests), ptr (last owner), excl_en/excl (optional excluded index), found/idx (winner)
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  sel_t             ptr,
  input  logic             excl_en,
  input  sel_t             excl,
  output logic             found,
  output sel_t             idx
);
  logic [N_REQ-1:0] m;
  always_comb begin
    m = req;
    if (excl_en) m[excl] = 1'b0;
    found = |m;
    idx = ptr;
    // walk from farthest (ptr itself) to nearest (ptr+1) so the nearest set bit wins
    for (int k = N_REQ; k >= 1; k--)
      if (m[ptr + sel_t'(k)]) idx = ptr + sel_t'(k);
  end
endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter with hold limit driving the select of a shared 4:1 mux
// ports: clk, rst (async active-high), req[3:0] in; gnt[3:0] one-hot grant, S mux select, busy out
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [1:0]       S,
  output logic             busy
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  sel_t             s_q, s_d, ptr_q, ptr_d, idx;
  logic [HW-1:0]    hold_q, hold_d;
  logic             busy_q, busy_d;
  logic             found, owner_req, others, at_max, preempt, take, release_g;
  assign owner_req = req[ptr_q];
  assign others    = |(req & ~gnt_q);
  assign at_max    = hold_q == HW'(MAX_HOLD);
  assign preempt   = state_q == GRANT && owner_req && others && at_max;
  rr_pick4 u_pick (
    .req(req), .ptr(ptr_q), .excl_en(preempt), .excl(ptr_q), .found(found), .idx(idx)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) state_d = found ? GRANT : IDLE;
    else state_d = (!owner_req && !others) ? IDLE : GRANT;
  end
  always_comb begin
    // take: a new winner is installed; release_g: owner left with nobody waiting
    take      = state_q == IDLE ? found : (!owner_req ? others : preempt);
    release_g = state_q == GRANT && !owner_req && !others;
    gnt_d     = take ? (4'b0001 << idx) : (release_g ? '0 : gnt_q);
    s_d       = take ? idx : s_q;
    ptr_d     = take ? idx : ptr_q;
    hold_d    = take ? HW'(1) : (state_q == GRANT && !release_g && !at_max ? hold_q + HW'(1) : hold_q);
    busy_d    = |gnt_d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q  <= '0;
      s_q    <= '0;
      ptr_q  <= 2'd3;
      hold_q <= '0;
      busy_q <= 1'b0;
    end else begin
      gnt_q  <= gnt_d;
      s_q    <= s_d;
      ptr_q  <= ptr_d;
      hold_q <= hold_d;
      busy_q <= busy_d;
    end
  end
  assign gnt  = gnt_q;
  assign S    = s_q;
  assign busy = busy_q;
  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
  a_busy:   assert property (@(posedge clk) disable iff (rst) busy_q == |gnt_q);
  a_sel:    assert property (@(posedge clk) disable iff (rst) busy_q |-> gnt_q[s_q]);
  a_legal:  assert property (@(posedge clk) disable iff (rst) !$past(rst) |-> (gnt_q & ~$past(req)) == '0);
endmodule
